// File: rtl/key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_sbox                                                     |
// | Description : AES forward S-box. Computes the GF(2^8) multiplicative       |
// |               inverse (x^254, which also maps 0 to 0) followed by the      |
// |               AES affine transform.                                        |
// | Ports       : in_byte  [7:0] in  - byte to substitute                      |
// |               out_byte [7:0] out - substituted byte                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] acc;
    prod = 8'h00;
    acc  = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) prod = prod ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return prod;
  endfunction

  logic [7:0] x2, x3, x12, x15, x240, x252, inv;

  // Addition chain for x^254: 2, 3, 12, 15, 240, 252, 254.
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(gf_mul(gf_mul(x15, x15), gf_mul(x15, x15)),
                  gf_mul(gf_mul(x15, x15), gf_mul(x15, x15)));
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

// +----------------------------------------------------------------------------+
// | Module      : key_expander                                                 |
// | Description : Sequential AES key schedule. One schedule word is produced   |
// |               per clock and kept in an NW x 32 register file; any round    |
// |               key can then be read with one cycle of latency.              |
// | Ports       : clk        in   clock, rising edge                           |
// |               rst_n      in   asynchronous active-low reset                |
// |               start_in   in   request to expand key_in (ignored if busy)   |
// |               key_in     in   cipher key, byte 0 at bits 0:7               |
// |               round_in   in   round-key select 0..NR                       |
// |               out        out  registered round key {w[4r]..w[4r+3]}        |
// |               busy_out   out  expansion in progress                        |
// |               done_out   out  one-cycle pulse after the last word write    |
// |               ready_out  out  stored schedule is complete and valid        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_in,
  input  logic [0:KEY_BITS-1] key_in,
  input  logic [0:3]          round_in,
  output logic [0:127]        out,
  output logic                busy_out,
  output logic                done_out,
  output logic                ready_out
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_IDX   = 6'(NK);
  localparam logic [5:0] LAST_IDX = 6'(NW - 1);
  localparam logic [3:0] NR_VAL   = 4'(NR);
  localparam logic [2:0] NK_LAST  = 3'(NK - 1);

  generate
    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
      $error("key_expander: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] words [NW];
  logic [5:0]  idx;        // index of the word written this cycle
  logic [2:0]  phase;      // idx mod NK, kept as a wrap-around counter
  logic [7:0]  rcon;

  logic        start_accept;
  logic        last_write;
  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] new_word;
  logic [7:0]  rcon_next;
  logic        rd_ok;
  logic [5:0]  rd_base;

  assign start_accept = (state == IDLE) && start_in;
  assign last_write   = (state == EXPAND) && (idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_out   = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) state_next = EXPAND;
      end
      EXPAND: begin
        busy_out = 1'b1;
        if (idx == LAST_IDX) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word datapath
  // ---------------------------------------------------------------------------
  // Operand reads are only meaningful in EXPAND, where idx >= NK.
  assign prev_word = words[idx - 6'd1];
  assign back_word = words[idx - NK_IDX];

  // RotWord is only applied on the Rcon step; the AES-256 mid-key step
  // substitutes the unrotated word.
  assign sub_in = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (sub_in[8*b +: 8]),
        .out_byte (sub_out[8*b +: 8])
      );
    end
  endgenerate

  always_comb begin
    temp = prev_word;
    if (phase == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if ((NK == 8) && (phase == 3'd4)) begin
      temp = sub_out;
    end
  end

  assign new_word  = back_word ^ temp;
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // Schedule storage carries no reset; ready_out guards every read.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      for (int k = 0; k < NK; k++) begin
        words[k] <= key_in[32*k +: 32];
      end
    end else if (state == EXPAND) begin
      words[idx] <= new_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 6'd0;
      phase     <= 3'd0;
      rcon      <= 8'h01;
      done_out  <= 1'b0;
      ready_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (start_accept) begin
        idx       <= NK_IDX;
        phase     <= 3'd0;
        rcon      <= 8'h01;
        ready_out <= 1'b0;
      end else if (state == EXPAND) begin
        idx   <= idx + 6'd1;
        phase <= (phase == NK_LAST) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= rcon_next;
        if (last_write) begin
          done_out  <= 1'b1;
          ready_out <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-key read port
  // ---------------------------------------------------------------------------
  assign rd_ok   = ready_out && (round_in <= NR_VAL);
  // Forcing the base to 0 when invalid keeps every read index inside the array.
  assign rd_base = rd_ok ? {round_in, 2'b00} : 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 128'h0;
    end else if (rd_ok) begin
      out <= {words[rd_base], words[rd_base + 6'd1],
              words[rd_base + 6'd2], words[rd_base + 6'd3]};
    end else begin
      out <= 128'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_expander                                              |
// | Description : Directed self-checking bench for key_expander, with one      |
// |               instance per legal key size sharing clock and reset.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         start128, busy128, done128, ready128;
  logic [0:127] key128;
  logic [0:3]   round128;
  logic [0:127] out128;

  logic         start192, busy192, done192, ready192;
  logic [0:191] key192;
  logic [0:3]   round192;
  logic [0:127] out192;

  logic         start256, busy256, done256, ready256;
  logic [0:255] key256;
  logic [0:3]   round256;
  logic [0:127] out256;

  int total = 0;
  int bad   = 0;

  localparam logic [0:255] KEY_A   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] KEY_Z   = 256'h0;
  localparam logic [0:255] KEY_192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] KEY_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_expander #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start_in(start128), .key_in(key128), .round_in(round128),
    .out(out128), .busy_out(busy128), .done_out(done128), .ready_out(ready128)
  );

  key_expander #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rst_n(rst_n), .start_in(start192), .key_in(key192), .round_in(round192),
    .out(out192), .busy_out(busy192), .done_out(done192), .ready_out(ready192)
  );

  key_expander #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start_in(start256), .key_in(key256), .round_in(round256),
    .out(out256), .busy_out(busy256), .done_out(done256), .ready_out(ready256)
  );

  // One-cycle start pulse; returns 1 time unit after the capture edge.
  task automatic do_start(input int which, input logic [0:255] k);
    @(negedge clk);
    case (which)
      128:     begin key128 = k[0:127]; start128 = 1'b1; end
      192:     begin key192 = k[0:191]; start192 = 1'b1; end
      default: begin key256 = k;        start256 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    start128 = 1'b0;
    start192 = 1'b0;
    start256 = 1'b0;
  endtask

  // Counts rising edges after the current point until done_out is seen; -1 on timeout.
  task automatic wait_done(input int which, output int edges);
    logic d;
    edges = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      case (which)
        128:     d = done128;
        192:     d = done192;
        default: d = done256;
      endcase
      if (d) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic read_round(input int which, input logic [3:0] r, output logic [0:127] v);
    @(negedge clk);
    case (which)
      128:     round128 = r;
      192:     round192 = r;
      default: round256 = r;
    endcase
    @(posedge clk);
    #1;
    case (which)
      128:     v = out128;
      192:     v = out192;
      default: v = out256;
    endcase
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
    key128 = '0; key192 = '0; key256 = '0;
    round128 = 4'd0; round192 = 4'd0; round256 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy128 !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy128); end
    total++; if (done128 !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done128); end
    total++; if (ready128 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready128); end
    total++; if (out128 !== 128'h0) begin bad++; $display("FAIL reset_out: got %h want 0", out128); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_before_done;
    logic [0:127] v;
    read_round(128, 4'd0, v);
    total++; if (v !== 128'h0) begin bad++; $display("FAIL early_read128: got %h want 0", v); end
    read_round(192, 4'd0, v);
    total++; if (v !== 128'h0) begin bad++; $display("FAIL early_read192: got %h want 0", v); end
  endtask

  task automatic test_expand_128;
    int e;
    logic [0:127] v;
    do_start(128, KEY_A);
    total++; if (busy128 !== 1'b1)  begin bad++; $display("FAIL e128_busy: got %b want 1", busy128); end
    wait_done(128, e);
    // Counting the start cycle itself, done_out appears 41 cycles on.
    total++; if (e + 1 != 41) begin bad++; $display("FAIL e128_latency: got %0d want 41", e + 1); end
    total++; if (busy128 !== 1'b0)  begin bad++; $display("FAIL e128_busy_end: got %b want 0", busy128); end
    @(posedge clk); #1;
    total++; if (done128 !== 1'b0)  begin bad++; $display("FAIL e128_done_pulse: got %b want 0", done128); end
    total++; if (ready128 !== 1'b1) begin bad++; $display("FAIL e128_ready: got %b want 1", ready128); end
    read_round(128, 4'd0, v);
    total++; if (v !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin bad++; $display("FAIL e128_r0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", v); end
    read_round(128, 4'd1, v);
    total++; if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin bad++; $display("FAIL e128_r1: got %h want a0fafe1788542cb123a339392a6c7605", v); end
    read_round(128, 4'd2, v);
    total++; if (v !== 128'hf2c295f27a96b9435935807a7359f67f) begin bad++; $display("FAIL e128_r2: got %h want f2c295f27a96b9435935807a7359f67f", v); end
    read_round(128, 4'd10, v);
    total++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin bad++; $display("FAIL e128_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
    read_round(128, 4'd15, v);
    total++; if (v !== 128'h0) begin bad++; $display("FAIL e128_r15: got %h want 0", v); end
  endtask

  task automatic test_expand_192;
    int e;
    logic [0:127] v;
    do_start(192, KEY_192);
    wait_done(192, e);
    total++; if (e != 46) begin bad++; $display("FAIL e192_latency: got %0d want 46", e); end
    read_round(192, 4'd0, v);
    total++; if (v !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin bad++; $display("FAIL e192_r0: got %h want 8e73b0f7da0e6452c810f32b809079e5", v); end
    read_round(192, 4'd12, v);
    total++; if (v !== 128'he98ba06f448c773c8ecc720401002202) begin bad++; $display("FAIL e192_r12: got %h want e98ba06f448c773c8ecc720401002202", v); end
    read_round(192, 4'd13, v);
    total++; if (v !== 128'h0) begin bad++; $display("FAIL e192_r13: got %h want 0", v); end
  endtask

  task automatic test_expand_256;
    int e;
    logic [0:127] v;
    do_start(256, KEY_256);
    wait_done(256, e);
    total++; if (e != 52) begin bad++; $display("FAIL e256_latency: got %0d want 52", e); end
    read_round(256, 4'd1, v);
    total++; if (v !== 128'h1f352c073b6108d72d9810a30914dff4) begin bad++; $display("FAIL e256_r1: got %h want 1f352c073b6108d72d9810a30914dff4", v); end
    read_round(256, 4'd14, v);
    total++; if (v !== 128'hfe4890d1e6188d0b046df344706c631e) begin bad++; $display("FAIL e256_r14: got %h want fe4890d1e6188d0b046df344706c631e", v); end
    read_round(256, 4'd15, v);
    total++; if (v !== 128'h0) begin bad++; $display("FAIL e256_r15: got %h want 0", v); end
  endtask

  task automatic test_start_ignored;
    int e;
    logic [0:127] v;
    do_start(128, KEY_A);
    repeat (9) @(posedge clk);
    // Second request lands on the 10th edge of the running expansion.
    do_start(128, KEY_Z);
    wait_done(128, e);
    total++; if (10 + e != 40) begin bad++; $display("FAIL ign_latency: got %0d want 40", 10 + e); end
    read_round(128, 4'd10, v);
    total++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin bad++; $display("FAIL ign_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
    read_round(128, 4'd0, v);
    total++; if (v !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin bad++; $display("FAIL ign_r0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", v); end
  endtask

  task automatic test_back_to_back;
    int e;
    logic [0:127] v;
    do_start(128, KEY_Z);
    total++; if (ready128 !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop: got %b want 0", ready128); end
    total++; if (busy128 !== 1'b1)  begin bad++; $display("FAIL b2b_busy: got %b want 1", busy128); end
    wait_done(128, e);
    total++; if (e != 40) begin bad++; $display("FAIL b2b_latency: got %0d want 40", e); end
    read_round(128, 4'd0, v);
    total++; if (v !== 128'h0) begin bad++; $display("FAIL b2b_r0: got %h want 0", v); end
    read_round(128, 4'd10, v);
    total++; if (v !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin bad++; $display("FAIL b2b_r10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", v); end
    read_round(128, 4'd1, v);
    total++; if (v !== 128'h62636363626363636263636362636363) begin bad++; $display("FAIL b2b_r1: got %h want 62636363626363636263636362636363", v); end
  endtask

  task automatic test_reset_mid;
    int e;
    logic seen;
    logic [0:127] v;
    // round128 is still 1 from the previous task, so out holds a live key.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (out128 !== 128'h0)  begin bad++; $display("FAIL rst_ready_out: got %h want 0", out128); end
    total++; if (ready128 !== 1'b0) begin bad++; $display("FAIL rst_ready_flag: got %b want 0", ready128); end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(128, KEY_A);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy128 !== 1'b0)  begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy128); end
    total++; if (ready128 !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: got %b want 0", ready128); end
    total++; if (done128 !== 1'b0)  begin bad++; $display("FAIL rst_mid_done: got %b want 0", done128); end
    total++; if (out128 !== 128'h0) begin bad++; $display("FAIL rst_mid_out: got %h want 0", out128); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (done128 || ready128 || busy128) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet: got %b want 0", seen); end
    do_start(128, KEY_A);
    wait_done(128, e);
    total++; if (e != 40) begin bad++; $display("FAIL rst_restart_latency: got %0d want 40", e); end
    read_round(128, 4'd1, v);
    total++; if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin bad++; $display("FAIL rst_restart_r1: got %h want a0fafe1788542cb123a339392a6c7605", v); end
  endtask

  initial begin
    test_reset;
    test_read_before_done;
    test_expand_128;
    test_expand_192;
    test_expand_256;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
